hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: stall  input  1  load-use hazard from decode-stage hazard detection (combinational, same cycle).
REQ-004 SHALL have port: cannot_calcpc  input  1  decode cannot compute next PC (branch, or jalr with rs1 hazard).
REQ-005 SHALL have port: resolveE  input  1  execute stage holds resolved branch/jalr this cycle.
REQ-006 SHALL have port: takenE  input  1  resolved control transfer taken; valid only with resolveE.
REQ-007 SHALL have port: targetE  input  32  resolved target address; valid only with resolveE and takenE.
REQ-008 SHALL have port: pc_enF  output  1  PC register update enable.
REQ-009 SHALL have port: ifid_en  output  1  IF/ID pipeline register load enable.
REQ-010 SHALL have port: ifid_flush  output  1  IF/ID loads NOP bubble.
REQ-011 SHALL have port: idex_flush  output  1  ID/EX loads NOP bubble.
REQ-012 SHALL have port: pc_redirect  output  1  PC loads pc_redirect_addr instead of PC+4.
REQ-013 SHALL have port: pc_redirect_addr  output  32  redirect target.
REQ-014 SHALL have port: busy  output  1  high when state is not RUN.
REQ-015 SHALL have port: perf_stall_cnt  output  32  load-use stall cycle count.
REQ-016 SHALL have port: perf_redirect_cnt  output  32  taken redirect count.

Function
REQ-017 SHALL implement two-state FSM: RUN, WAIT_E; outputs are Mealy (state plus current inputs), zero added latency.
REQ-018 RUN, stall=1: pc_enF=0, ifid_en=0, ifid_flush=0, idex_flush=1, pc_redirect=0; state stays RUN.
REQ-019 RUN, stall=0, cannot_calcpc=1: pc_enF=0, ifid_en=1, ifid_flush=1, idex_flush=0; next state WAIT_E.
REQ-020 RUN, stall=0, cannot_calcpc=0: pc_enF=1, ifid_en=1, all flushes 0, pc_redirect=0.
REQ-021 stall and cannot_calcpc both high in RUN: stall wins per REQ-018; no transition.
REQ-022 WAIT_E, resolveE=0: pc_enF=0, ifid_en=1, ifid_flush=1, idex_flush=1 (hazard still pending); state stays WAIT_E, no cycle limit.
REQ-023 WAIT_E, resolveE=1, takenE=1: pc_enF=1, pc_redirect=1, pc_redirect_addr=targetE, ifid_flush=1, idex_flush=0; next state RUN.
REQ-024 WAIT_E, resolveE=1, takenE=0: pc_enF=1, pc_redirect=0, ifid_flush=1, idex_flush=0; next state RUN.
REQ-025 stall and cannot_calcpc SHALL be ignored in WAIT_E.
REQ-026 pc_redirect_addr SHALL equal targetE whenever pc_redirect=1, else 32'd0.
REQ-027 resolveE in RUN SHALL be ignored (no redirect, no state change).

Reset
REQ-028 rst=1 at a clock edge SHALL force state RUN and zero both counters, including mid-WAIT_E.
REQ-029 While rst=1: pc_enF=0, ifid_en=0, ifid_flush=1, idex_flush=1, pc_redirect=0, pc_redirect_addr=0, busy=0.
REQ-030 First cycle after rst deasserts SHALL behave as RUN per REQ-018..020.

Configuration
REQ-031 Macro HAZARD_PERF_EN SHALL gate performance counters.
REQ-032 With HAZARD_PERF_EN: perf_stall_cnt +1 each cycle REQ-018 applies; perf_redirect_cnt +1 each cycle REQ-023 applies; both wrap 32'hFFFFFFFF->0.
REQ-033 Without HAZARD_PERF_EN: no counter registers; both outputs constant 32'd0; ports retained.

Verification
REQ-034 RUN, stall=1 one cycle -> pc_enF=0, ifid_en=0, idex_flush=1; next cycle stall=0 -> pc_enF=1; perf_stall_cnt=1 (macro on).
REQ-035 cannot_calcpc=1, then 2 cycles resolveE=0, then resolveE=1 takenE=1 targetE=32'h00000100 -> busy high 3 cycles, pc_redirect=1 with addr 32'h00000100 in resolve cycle, RUN next.
REQ-036 WAIT_E then resolveE=1 takenE=0 -> pc_redirect=0, pc_enF=1, ifid_flush=1, state RUN, perf_redirect_cnt unchanged.
REQ-037 stall=1 and cannot_calcpc=1 same cycle in RUN -> stall behaviour, busy=0 next cycle.
REQ-038 rst=1 during WAIT_E with resolveE=1 takenE=1 -> pc_redirect=0, state RUN, counters 0 after edge.
REQ-039 Counter preloaded 32'hFFFFFFFF, one stall cycle -> perf_stall_cnt=0; macro off -> both counters read 0 throughout.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, decode-time PC hold and execute-stage redirect.
// Define HAZARD_PERF_EN to build the stall/redirect performance counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        cannot_calcpc,
    input  logic        resolveE,
    input  logic        takenE,
    input  logic [31:0] targetE,
    output logic        pc_enF,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pc_redirect,
    output logic [31:0] pc_redirect_addr,
    output logic        busy,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redirect_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        WAIT_E = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next  = state;
        pc_enF      = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pc_redirect = 1'b0;

        if (rst) begin
            // Hold the PC and bubble both stages while in reset.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_next = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (stall) begin
                        idex_flush = 1'b1;
                    end else if (cannot_calcpc) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        state_next = WAIT_E;
                    end else begin
                        pc_enF  = 1'b1;
                        ifid_en = 1'b1;
                    end
                end
                WAIT_E: begin
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    if (resolveE) begin
                        pc_enF      = 1'b1;
                        pc_redirect = takenE;
                        state_next  = RUN;
                    end else begin
                        idex_flush = 1'b1;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign pc_redirect_addr = pc_redirect ? targetE : 32'd0;
    assign busy             = !rst && (state == WAIT_E);

`ifdef HAZARD_PERF_EN
    logic        stall_evt;
    logic        redirect_evt;
    logic [31:0] stall_cnt_q;
    logic [31:0] redirect_cnt_q;

    assign stall_evt    = !rst && (state == RUN) && stall;
    assign redirect_evt = !rst && (state == WAIT_E) && resolveE && takenE;

    // Counters wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q    <= 32'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            if (stall_evt)    stall_cnt_q    <= stall_cnt_q + 32'd1;
            if (redirect_evt) redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt    = stall_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`else
    assign perf_stall_cnt    = 32'd0;
    assign perf_redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl; counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        cannot_calcpc;
    logic        resolveE;
    logic        takenE;
    logic [31:0] targetE;
    logic        pc_enF;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        pc_redirect;
    logic [31:0] pc_redirect_addr;
    logic        busy;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redirect_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Model of the counters; stays zero when the counters are not built.
    logic [31:0] exp_stall = 32'd0;
    logic [31:0] exp_redir = 32'd0;

    // {pc_enF, ifid_en, ifid_flush, idex_flush, pc_redirect, busy}
    logic [5:0] ctrl;
    assign ctrl = {pc_enF, ifid_en, ifid_flush, idex_flush, pc_redirect, busy};

    hazard_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .cannot_calcpc     (cannot_calcpc),
        .resolveE          (resolveE),
        .takenE            (takenE),
        .targetE           (targetE),
        .pc_enF            (pc_enF),
        .ifid_en           (ifid_en),
        .ifid_flush        (ifid_flush),
        .idex_flush        (idex_flush),
        .pc_redirect       (pc_redirect),
        .pc_redirect_addr  (pc_redirect_addr),
        .busy              (busy),
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the falling edge and let them settle.
    task automatic drive(input logic r, input logic s, input logic c, input logic re,
                         input logic tk, input logic [31:0] tg);
        @(negedge clk);
        rst = r; stall = s; cannot_calcpc = c; resolveE = re; takenE = tk; targetE = tg;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        n_total++;
        if (ctrl !== 6'b001100) begin
            n_bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 6'b001100);
        end
        n_total++;
        if (pc_redirect_addr !== 32'd0) begin
            n_bad++; $display("FAIL reset_addr got=%h exp=%h", pc_redirect_addr, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (ctrl !== 6'b110000) begin
            n_bad++; $display("FAIL reset_first_run got=%b exp=%b", ctrl, 6'b110000);
        end
        n_total++;
        if (perf_stall_cnt !== 32'd0 || perf_redirect_cnt !== 32'd0) begin
            n_bad++; $display("FAIL reset_counters got=%h/%h exp=0/0", perf_stall_cnt, perf_redirect_cnt);
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (ctrl !== 6'b000100) begin
            n_bad++; $display("FAIL stall_ctrl got=%b exp=%b", ctrl, 6'b000100);
        end
`ifdef HAZARD_PERF_EN
        exp_stall = exp_stall + 32'd1;
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (ctrl !== 6'b110000) begin
            n_bad++; $display("FAIL stall_release got=%b exp=%b", ctrl, 6'b110000);
        end
        n_total++;
        if (perf_stall_cnt !== exp_stall) begin
            n_bad++; $display("FAIL stall_count got=%h exp=%h", perf_stall_cnt, exp_stall);
        end
    endtask

    task automatic test_branch_taken();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (ctrl !== 6'b011000) begin
            n_bad++; $display("FAIL br_decode got=%b exp=%b", ctrl, 6'b011000);
        end
        // Second wait cycle also drives stall/cannot_calcpc, which must be ignored.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, i[0], i[0], 1'b0, 1'b1, 32'h0000_0F00);
            n_total++;
            if (ctrl !== 6'b011101) begin
                n_bad++; $display("FAIL br_wait%0d got=%b exp=%b", i, ctrl, 6'b011101);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        n_total++;
        if (ctrl !== 6'b111011) begin
            n_bad++; $display("FAIL br_resolve got=%b exp=%b", ctrl, 6'b111011);
        end
        n_total++;
        if (pc_redirect_addr !== 32'h0000_0100) begin
            n_bad++; $display("FAIL br_addr got=%h exp=%h", pc_redirect_addr, 32'h0000_0100);
        end
`ifdef HAZARD_PERF_EN
        exp_redir = exp_redir + 32'd1;
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (ctrl !== 6'b110000) begin
            n_bad++; $display("FAIL br_back_run got=%b exp=%b", ctrl, 6'b110000);
        end
        n_total++;
        if (perf_redirect_cnt !== exp_redir) begin
            n_bad++; $display("FAIL br_count got=%h exp=%h", perf_redirect_cnt, exp_redir);
        end
    endtask

    task automatic test_not_taken();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200);
        n_total++;
        if (ctrl !== 6'b111001) begin
            n_bad++; $display("FAIL nt_resolve got=%b exp=%b", ctrl, 6'b111001);
        end
        n_total++;
        if (pc_redirect_addr !== 32'd0) begin
            n_bad++; $display("FAIL nt_addr got=%h exp=%h", pc_redirect_addr, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (ctrl !== 6'b110000) begin
            n_bad++; $display("FAIL nt_back_run got=%b exp=%b", ctrl, 6'b110000);
        end
        n_total++;
        if (perf_redirect_cnt !== exp_redir) begin
            n_bad++; $display("FAIL nt_count got=%h exp=%h", perf_redirect_cnt, exp_redir);
        end
    endtask

    task automatic test_stall_priority();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (ctrl !== 6'b000100) begin
            n_bad++; $display("FAIL prio_ctrl got=%b exp=%b", ctrl, 6'b000100);
        end
`ifdef HAZARD_PERF_EN
        exp_stall = exp_stall + 32'd1;
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (ctrl !== 6'b110000) begin
            n_bad++; $display("FAIL prio_next got=%b exp=%b", ctrl, 6'b110000);
        end
        n_total++;
        if (perf_stall_cnt !== exp_stall) begin
            n_bad++; $display("FAIL prio_count got=%h exp=%h", perf_stall_cnt, exp_stall);
        end
    endtask

    task automatic test_resolve_in_run();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
        n_total++;
        if (ctrl !== 6'b110000 || pc_redirect_addr !== 32'd0) begin
            n_bad++; $display("FAIL run_resolve got=%b/%h exp=%b/%h", ctrl, pc_redirect_addr, 6'b110000, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL run_resolve_busy got=%b exp=%b", busy, 1'b0);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0400);
        n_total++;
        if (ctrl !== 6'b001100 || pc_redirect_addr !== 32'd0) begin
            n_bad++; $display("FAIL rstwait_ctrl got=%b/%h exp=%b/%h", ctrl, pc_redirect_addr, 6'b001100, 32'd0);
        end
        exp_stall = 32'd0;
        exp_redir = 32'd0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (ctrl !== 6'b110000) begin
            n_bad++; $display("FAIL rstwait_run got=%b exp=%b", ctrl, 6'b110000);
        end
        n_total++;
        if (perf_stall_cnt !== 32'd0 || perf_redirect_cnt !== 32'd0) begin
            n_bad++; $display("FAIL rstwait_counters got=%h/%h exp=0/0", perf_stall_cnt, perf_redirect_cnt);
        end
    endtask

    task automatic test_wrap();
`ifdef HAZARD_PERF_EN
        @(negedge clk);
        dut.stall_cnt_q = 32'hFFFF_FFFF;
        exp_stall = 32'hFFFF_FFFF;
`endif
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef HAZARD_PERF_EN
        exp_stall = exp_stall + 32'd1;
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        n_total++;
        if (perf_stall_cnt !== exp_stall || perf_redirect_cnt !== exp_redir) begin
            n_bad++; $display("FAIL wrap_counters got=%h/%h exp=%h/%h", perf_stall_cnt, perf_redirect_cnt, exp_stall, exp_redir);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; cannot_calcpc = 1'b0;
        resolveE = 1'b0; takenE = 1'b0; targetE = 32'd0;
        test_reset();
        test_stall();
        test_branch_taken();
        test_not_taken();
        test_stall_priority();
        test_resolve_in_run();
        test_reset_mid_wait();
        test_wrap();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
